// File: rtl/inst_loader.sv
// Instruction loader: receives a framed program image over a byte stream,
// writes it word by word into instruction memory, checks the frame checksum,
// reads the memory back to verify it, and then releases the CPU from reset.
//
// Frame: SYNC, N (words), 4N payload bytes (big-endian per word), checksum
// (8-bit sum of the payload bytes).
//
// Ports
//   clock      : single clock, rising edge
//   resetn     : synchronous active-low reset
//   rx_data    : received byte
//   rx_valid   : rx_data valid
//   rx_ready   : loader accepts a byte this cycle
//   ram_a      : instruction memory byte address (word aligned)
//   d_t_ram    : write data to instruction memory
//   wram       : write strobe, one cycle per word
//   d_f_ram    : asynchronous read data for ram_a
//   cpu_resetn : CPU reset, released only after a verified load
//   done       : load completed and verified
//   error      : frame rejected
//   word_cnt   : words written in current frame
module inst_loader #(
  parameter logic [7:0]  SYNC      = 8'hA5,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] ram_a,
  output logic [31:0] d_t_ram,
  output logic        wram,
  input  logic [31:0] d_f_ram,
  output logic        cpu_resetn,
  output logic        done,
  output logic        error,
  output logic [6:0]  word_cnt
);

  localparam logic [7:0] MaxWords = 8'(MAX_WORDS);

  typedef enum logic [2:0] {
    StSync, StLen, StData, StWrite, StCheck, StVerify, StDone, StErr
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  n_q, n_d;
  logic [6:0]  idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  vsum_q, vsum_d;
  logic [31:0] word_q, word_d;
  logic [6:0]  wc_q, wc_d;

  logic       take;
  logic [6:0] idx_inc;
  logic [7:0] rd_sum;

  assign take    = rx_valid && rx_ready;
  assign idx_inc = idx_q + 7'd1;
  // Modulo-256 sum of the word currently read back from memory.
  assign rd_sum  = d_f_ram[31:24] + d_f_ram[23:16] + d_f_ram[15:8] + d_f_ram[7:0];

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    sum_d   = sum_q;
    vsum_d  = vsum_q;
    word_d  = word_q;
    wc_d    = wc_q;
    unique case (state_q)
      StSync: begin
        if (take && rx_data == SYNC) state_d = StLen;
      end
      StLen: begin
        if (take) begin
          if (rx_data != 8'd0 && rx_data <= MaxWords) begin
            state_d = StData;
            n_d     = rx_data[6:0];
            idx_d   = 7'd0;
            bcnt_d  = 2'd0;
            sum_d   = 8'd0;
            wc_d    = 7'd0;
          end else begin
            state_d = StErr;
          end
        end
      end
      StData: begin
        if (take) begin
          word_d = {word_q[23:0], rx_data};
          sum_d  = sum_q + rx_data;
          bcnt_d = bcnt_q + 2'd1;  // wraps to 0 after the 4th byte
          if (bcnt_q == 2'd3) state_d = StWrite;
        end
      end
      StWrite: begin
        idx_d   = idx_inc;
        wc_d    = wc_q + 7'd1;
        state_d = (idx_inc == n_q) ? StCheck : StData;
      end
      StCheck: begin
        if (take) begin
          if (rx_data == sum_q) begin
            state_d = StVerify;
            idx_d   = 7'd0;
            vsum_d  = 8'd0;
          end else begin
            state_d = StErr;
          end
        end
      end
      StVerify: begin
        vsum_d = vsum_q + rd_sum;
        if (idx_inc == n_q) begin
          state_d = (vsum_d == sum_q) ? StDone : StErr;
        end else begin
          idx_d = idx_inc;
        end
      end
      StDone: ;
      StErr: begin
        if (take && rx_data == SYNC) state_d = StLen;
      end
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= StSync;
      n_q     <= 7'd0;
      idx_q   <= 7'd0;
      bcnt_q  <= 2'd0;
      sum_q   <= 8'd0;
      vsum_q  <= 8'd0;
      word_q  <= 32'd0;
      wc_q    <= 7'd0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      sum_q   <= sum_d;
      vsum_q  <= vsum_d;
      word_q  <= word_d;
      wc_q    <= wc_d;
    end
  end

  always_comb begin
    rx_ready   = 1'b0;
    wram       = 1'b0;
    ram_a      = 32'd0;
    d_t_ram    = 32'd0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_resetn = 1'b0;
    unique case (state_q)
      StSync, StLen, StData, StCheck: rx_ready = resetn;
      StWrite: begin
        wram    = 1'b1;
        ram_a   = {24'd0, idx_q[5:0], 2'b00};
        d_t_ram = word_q;
      end
      StVerify: ram_a = {24'd0, idx_q[5:0], 2'b00};
      StDone: begin
        done       = 1'b1;
        cpu_resetn = 1'b1;
      end
      StErr: begin
        error    = 1'b1;
        rx_ready = resetn;
      end
      default: ;
    endcase
  end

  assign word_cnt = wc_q;

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] ram_a;
  logic [31:0] d_t_ram;
  logic        wram;
  logic [31:0] d_f_ram;
  logic        cpu_resetn;
  logic        done;
  logic        error;
  logic [6:0]  word_cnt;

  inst_loader #(.SYNC(8'hA5), .MAX_WORDS(64)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .ram_a     (ram_a),
    .d_t_ram   (d_t_ram),
    .wram      (wram),
    .d_f_ram   (d_f_ram),
    .cpu_resetn(cpu_resetn),
    .done      (done),
    .error     (error),
    .word_cnt  (word_cnt)
  );

  always #5 clock = ~clock;

  // Instruction memory with an optional read-back corruption.
  logic [31:0] mem [64];
  logic        vfail = 1'b0;
  assign d_f_ram = vfail ? 32'd0 : mem[ram_a[7:2]];
  always @(posedge clock) if (wram) mem[ram_a[7:2]] <= d_t_ram;

  int total = 0;
  int bad   = 0;

  // Model state for the current frame.
  logic [7:0]  frame_q[$];
  logic [31:0] exp_a_q[$];
  logic [31:0] exp_d_q[$];
  logic [7:0]  m_sum;
  logic        exp_done;
  int          exp_wc;
  int          exp_lat;
  int          stall_at = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle checker: writes against the model's expected write list, plus
  // output invariants.
  always @(negedge clock) begin
    if (wram) begin
      if (exp_a_q.size() == 0) begin
        chk("unexpected_wram", {31'd0, wram}, 32'd0);
      end else begin
        chk("wr_addr", ram_a, exp_a_q.pop_front());
        chk("wr_data", d_t_ram, exp_d_q.pop_front());
      end
    end
    chk("cpu_resetn_vs_done", {31'd0, cpu_resetn}, {31'd0, done});
    if (!resetn) chk("rx_ready_in_reset", {31'd0, rx_ready}, 32'd0);
    if (done || error) begin
      chk("idle_ram_a", ram_a, 32'd0);
      chk("idle_d_t_ram", d_t_ram, 32'd0);
      chk("idle_wram", {31'd0, wram}, 32'd0);
    end
  end

  // Builds the expected writes and outcome from frame_q.
  task automatic model_frame(input bit corrupt);
    int  n;
    bit  ok;
    bit  cs_ok;
    n = int'(frame_q[1]);
    ok = (n >= 1) && (n <= 64);
    m_sum = 8'd0;
    exp_a_q.delete();
    exp_d_q.delete();
    if (ok) begin
      for (int w = 0; w < n; w++) begin
        exp_a_q.push_back(32'(w * 4));
        exp_d_q.push_back({frame_q[2+4*w], frame_q[3+4*w], frame_q[4+4*w], frame_q[5+4*w]});
        for (int b = 0; b < 4; b++) m_sum = m_sum + frame_q[2+4*w+b];
      end
    end
    cs_ok    = ok && (frame_q.size() > 2 + 4 * n) && (frame_q[2+4*n] == m_sum);
    exp_done = cs_ok && (!corrupt || m_sum == 8'd0);
    exp_lat  = cs_ok ? n : 0;
    exp_wc   = ok ? n : 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 200) chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input string nm);
    int lat = 0;
    for (int i = 0; i < frame_q.size(); i++) begin
      if (i == stall_at) begin
        repeat (20) @(negedge clock);
        chk({nm, "_stall_wc"}, 32'(word_cnt), 32'((stall_at - 2) / 4));
        chk({nm, "_stall_ready"}, {31'd0, rx_ready}, 32'd1);
        chk({nm, "_stall_done"}, {31'd0, done | error}, 32'd0);
      end
      send_byte(frame_q[i]);
    end
    while (!(done || error) && lat < 300) begin
      @(negedge clock);
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_done"}, {31'd0, done}, {31'd0, exp_done});
    chk({nm, "_error"}, {31'd0, error}, {31'd0, !exp_done});
    chk({nm, "_cpu_resetn"}, {31'd0, cpu_resetn}, {31'd0, exp_done});
    chk({nm, "_word_cnt"}, 32'(word_cnt), 32'(exp_wc));
    chk({nm, "_writes_left"}, 32'(exp_a_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn   = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_flags", {28'd0, done, error, cpu_resetn, wram}, 32'd0);
    chk("rst_ram_a", ram_a, 32'd0);
    chk("rst_d_t_ram", d_t_ram, 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    resetn = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    logic [7:0] cs;
    do_reset();

    // Single word, with a long stall inside the payload.
    frame_q = {8'hA5, 8'h01, 8'h3C, 8'h03, 8'hC0, 8'h00, 8'hFF};
    model_frame(1'b0);
    chk("model_word_3c03c000", exp_d_q[0], 32'h3C03C000);
    chk("model_sum_ff", {24'd0, m_sum}, 32'h0000_00FF);
    stall_at = 3;
    run_frame("one_word");
    stall_at = -1;
    chk("one_word_done_lit", {30'd0, done, cpu_resetn}, 32'd3);
    chk("one_word_mem0", mem[0], 32'h3C03C000);

    // Two words 00..07.
    do_reset();
    frame_q = {8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h1C};
    model_frame(1'b0);
    chk("model_w0", exp_d_q[0], 32'h00010203);
    chk("model_w1", exp_d_q[1], 32'h04050607);
    chk("model_a1", exp_a_q[1], 32'd4);
    chk("model_sum_1c", {24'd0, m_sum}, 32'h1C);
    run_frame("two_word");
    chk("two_word_mem1", mem[1], 32'h04050607);

    // N=0 rejected, then recovery.
    do_reset();
    frame_q = {8'hA5, 8'h00};
    model_frame(1'b0);
    run_frame("len_zero");
    frame_q = {8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
    model_frame(1'b0);
    run_frame("recover");

    // Bad checksum.
    do_reset();
    frame_q = {8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    model_frame(1'b0);
    chk("model_sum_aa", {24'd0, m_sum}, 32'hAA);
    run_frame("bad_cs");
    chk("bad_cs_flags_lit", {29'd0, done, error, cpu_resetn}, 32'd2);

    // Read-back corrupted during verify.
    do_reset();
    frame_q = {8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    model_frame(1'b1);
    vfail = 1'b1;
    run_frame("verify_fail");
    vfail = 1'b0;

    // Reset mid-frame, then a fresh frame.
    do_reset();
    exp_a_q.delete();
    exp_d_q.delete();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    do_reset();
    chk("post_rst_ready", {31'd0, rx_ready}, 32'd1);
    chk("post_rst_flags", {29'd0, done, error, cpu_resetn}, 32'd0);
    frame_q = {8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38};
    model_frame(1'b0);
    run_frame("after_abort");

    // SYNC-valued payload bytes are data.
    do_reset();
    frame_q = {8'hA5, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h94};
    model_frame(1'b0);
    run_frame("sync_in_data");

    // Length one past the maximum is rejected.
    do_reset();
    frame_q = {8'hA5, 8'h41};
    model_frame(1'b0);
    run_frame("len_over");

    // Maximum length frame.
    do_reset();
    frame_q = {8'hA5, 8'h40};
    cs = 8'd0;
    for (int k = 0; k < 256; k++) begin
      frame_q.push_back(8'((k * 7 + 3) & 255));
      cs = cs + 8'((k * 7 + 3) & 255);
    end
    frame_q.push_back(cs);
    model_frame(1'b0);
    run_frame("len_max");
    chk("len_max_mem63", mem[63], {8'(252*7+3), 8'(253*7+3), 8'(254*7+3), 8'(255*7+3)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
